// File: rtl/display_pkg.sv
// Shared display constants and the frame-fill FSM encoding.
// Used by the ROM-to-FIFO fill sequencer; the VGA side reuses FRAME_PIX.
package display_pkg;

  localparam int unsigned DATA_W     = 24;     // {R,G,B}, 8 bits each
  localparam int unsigned ADDR_W     = 17;     // display ROM address width
  localparam int unsigned FRAME_PIX  = 76800;  // 320x240 pixels per frame
  localparam int unsigned ROM_LAT    = 2;      // rom_en to valid rom_data, cycles
  localparam int unsigned SKID_DEPTH = 4;      // skid entries, >= ROM_LAT+1

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } fill_state_e;

  // Sequencer is actively moving a frame.
  function automatic logic state_is_busy(fill_state_e s);
    return (s == ST_FILL) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Small first-word-fall-through register FIFO that catches ROM read data.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push_i      write data_i this cycle
//   data_i      pixel from the ROM
//   pop_i       consume the head entry this cycle (ignored when empty)
//   data_o      head entry, valid whenever count_o != 0
//   count_o     number of stored entries
module pix_skid_fifo #(
  parameter  int unsigned DATA_W     = 24,
  parameter  int unsigned SKID_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer/count update; a simultaneous push and pop keeps the count.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CNT_W'(SKID_DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  // Head is read straight from storage, so a fresh push is visible next cycle.
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // The upstream credit scheme must never push into a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && !pop_i && (cnt_q == CNT_W'(SKID_DEPTH))));

endmodule

// File: rtl/rom_fifo_fill_ctrl.sv
// Streams one frame of pixels from the synchronous display ROM into the write
// side of the pixel FIFO, restarting at address 0 after the VGA side's done.
// Ports:
//   clk, rst     clock, async active-low reset
//   enable       allow ROM fetches (0 pauses issue, position kept)
//   done         1-cycle pulse: VGA side consumed the frame
//   fifo_full    pixel FIFO full flag
//   rom_data     ROM read data, ROM_LAT cycles after rom_en
//   rom_en       ROM read strobe
//   rom_addr     ROM read address
//   fifo_din     FIFO write data (skid head)
//   fifo_wr_en   FIFO write enable
//   busy         sequencer in FILL or DRAIN
//   sync_err     sticky: done arrived before the frame was fully written
module rom_fifo_fill_ctrl #(
  parameter int unsigned DATA_W     = display_pkg::DATA_W,
  parameter int unsigned ADDR_W     = display_pkg::ADDR_W,
  parameter int unsigned FRAME_PIX  = display_pkg::FRAME_PIX,
  parameter int unsigned ROM_LAT    = display_pkg::ROM_LAT,
  parameter int unsigned SKID_DEPTH = display_pkg::SKID_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              done,
  input  logic              fifo_full,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic              sync_err
);

  import display_pkg::*;

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIX - 1);

  if (SKID_DEPTH < ROM_LAT + 1) begin : g_bad_skid_depth
    $error("SKID_DEPTH must be at least ROM_LAT+1");
  end
  if ((ROM_LAT < 1) || (ROM_LAT > 3)) begin : g_bad_rom_lat
    $error("ROM_LAT must be in 1..3");
  end

  fill_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0] infl_q, infl_d;
  logic               sync_err_q, sync_err_d;

  logic               issue_c;
  logic               credit_ok_c;
  logic [CNT_W-1:0]   infl_cnt_c;
  logic [CNT_W-1:0]   skid_cnt;
  logic [DATA_W-1:0]  skid_head;

  // Reads in flight plus stored pixels must leave room for one more landing.
  always_comb begin
    infl_cnt_c = '0;
    for (int i = 0; i < int'(ROM_LAT); i++) begin
      infl_cnt_c = infl_cnt_c + CNT_W'(infl_q[i]);
    end
    credit_ok_c = (SUM_W'(infl_cnt_c) + SUM_W'(skid_cnt)) < SUM_W'(SKID_DEPTH);
  end

  // Next-state, address and issue decode.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    sync_err_d = sync_err_q;
    issue_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_FILL;
          rom_addr_d = '0;
        end
      end
      ST_FILL: begin
        issue_c = enable && credit_ok_c;
        if (done) begin
          sync_err_d = 1'b1;
        end
        if (issue_c) begin
          if (rom_addr_q == ADDR_LAST) begin
            rom_addr_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (done) begin
          sync_err_d = 1'b1;
        end
        if ((infl_cnt_c == '0) && (skid_cnt == '0)) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done) begin
          state_d = enable ? ST_FILL : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In-flight tracker mirrors the ROM pipeline; its last stage marks valid rom_data.
  always_comb begin
    infl_d    = infl_q;
    infl_d[0] = issue_c;
    for (int i = 1; i < int'(ROM_LAT); i++) begin
      infl_d[i] = infl_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      infl_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      infl_q     <= infl_d;
      sync_err_q <= sync_err_d;
    end
  end

  pix_skid_fifo #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (infl_q[ROM_LAT-1]),
    .data_i  (rom_data),
    .pop_i   (fifo_wr_en),
    .data_o  (skid_head),
    .count_o (skid_cnt)
  );

  assign rom_en     = issue_c;
  assign rom_addr   = rom_addr_q;
  assign fifo_wr_en = (skid_cnt != '0) && !fifo_full;
  assign fifo_din   = skid_head;
  assign busy       = state_is_busy(state_q);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_rom_fifo_fill_ctrl.sv
// Directed bench for rom_fifo_fill_ctrl with a 16-pixel frame and a 2-cycle ROM model.
module tb_rom_fifo_fill_ctrl;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 17;
  localparam int unsigned FP = 16;
  localparam int unsigned RL = 2;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          done = 1'b0;
  logic          fifo_full = 1'b0;
  logic [DW-1:0] rom_data;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] fifo_din;
  logic          fifo_wr_en;
  logic          busy;
  logic          sync_err;

  rom_fifo_fill_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .FRAME_PIX(FP), .ROM_LAT(RL), .SKID_DEPTH(SD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .done(done), .fifo_full(fifo_full),
    .rom_data(rom_data), .rom_en(rom_en), .rom_addr(rom_addr), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Pixel content stored at each ROM address.
  function automatic logic [DW-1:0] pix(logic [AW-1:0] a);
    return {a[7:0], 8'hC3, a[15:8]} ^ 24'h5A0F33;
  endfunction

  // Two-stage synchronous ROM model.
  logic [DW-1:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_en ? pix(rom_addr) : 24'hBADBAD;
    rom_p2 <= rom_p1;
  end
  assign rom_data = rom_p2;

  int checks = 0;
  int errors = 0;
  int exp_addr = 0;
  int frame_wr = 0;
  int total_wr = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every FIFO write must carry the next pixel in address order.
  task automatic sb_sample();
    if (fifo_wr_en) begin
      chk("wr_data", 64'(fifo_din), 64'(pix(AW'(exp_addr))));
      chk("wr_while_full", 64'(fifo_full), 64'd0);
      exp_addr = (exp_addr + 1) % int'(FP);
      frame_wr++;
      total_wr++;
    end
  endtask

  task automatic step();
    #1;
    sb_sample();
    @(negedge clk);
  endtask

  task automatic wait_issue(int unsigned addr, int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      #1;
      hit = rom_en && (rom_addr == AW'(addr));
      sb_sample();
      @(negedge clk);
    end
    chk($sformatf("issue_addr_%0d_seen", addr), 64'(hit), 64'd1);
  endtask

  task automatic wait_first_write(int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      #1;
      if (fifo_wr_en) begin
        got = 1'b1;
        chk("first_write_is_addr0", 64'(fifo_din), 64'(pix(AW'(0))));
      end
      sb_sample();
      @(negedge clk);
    end
    chk("first_write_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_frame_end(int budget);
    logic hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      #1;
      hit = !busy && !fifo_wr_en && !rom_en;
      sb_sample();
      @(negedge clk);
    end
    chk("frame_end_seen", 64'(hit), 64'd1);
    chk("frame_write_count", 64'(frame_wr), 64'(FP));
    frame_wr = 0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        full;
    logic        dn;
    logic        x_rom_en;
    int unsigned x_addr;
    logic        x_wr;
    int unsigned x_din_addr;
    logic        x_busy;
    logic        x_serr;
  } vec_t;

  vec_t vecs[17];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int en_late;
    int wr_before;
    int en_cnt;

    // Startup: ROM issues from addr 0, first write 3 cycles after first rom_en,
    // then fifo_full held from row 8 until the credit limit stops issue.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 1'b0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1,  0, 1'b0, 0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1,  2, 1'b0, 0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1,  3, 1'b1, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1,  4, 1'b1, 1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1,  5, 1'b1, 2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1,  6, 1'b1, 3, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1,  7, 1'b0, 0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  8, 1'b0, 0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0,  8, 1'b0, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0,  8, 1'b0, 0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0,  8, 1'b1, 4, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1,  8, 1'b1, 5, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1,  9, 1'b1, 6, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b1, 7, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 11, 1'b1, 8, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs",
        64'({rom_en, rom_addr, fifo_wr_en, busy, sync_err, fifo_din}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven startup and back-pressure rows
    for (int r = 0; r < 17; r++) begin
      enable    = vecs[r].en;
      fifo_full = vecs[r].full;
      done      = vecs[r].dn;
      #1;
      chk($sformatf("row%0d_ctrl", r),
          64'({rom_en, rom_addr, fifo_wr_en, busy, sync_err}),
          64'({vecs[r].x_rom_en, AW'(vecs[r].x_addr), vecs[r].x_wr,
               vecs[r].x_busy, vecs[r].x_serr}));
      if (vecs[r].x_wr) begin
        chk($sformatf("row%0d_din", r), 64'(fifo_din), 64'(pix(AW'(vecs[r].x_din_addr))));
      end
      sb_sample();
      @(negedge clk);
    end

    // fifo_full held 20 cycles: issue stops, nothing written
    fifo_full = 1'b1;
    en_late   = 0;
    wr_before = total_wr;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i >= 3 && rom_en) en_late++;
      sb_sample();
      @(negedge clk);
    end
    chk("no_issue_while_full", 64'(en_late), 64'd0);
    chk("no_write_while_full", 64'(total_wr - wr_before), 64'd0);
    fifo_full = 1'b0;
    wait_frame_end(200);

    // WAIT_DONE holds still until done
    wr_before = total_wr;
    en_cnt    = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rom_en || busy) en_cnt++;
      sb_sample();
      @(negedge clk);
    end
    chk("wait_done_quiet", 64'({en_cnt, total_wr - wr_before}), 64'd0);
    chk("wait_done_rom_addr", 64'(rom_addr), 64'd0);

    // done restarts at addr 0; done during FILL sets sticky sync_err
    pulse_done();
    #1;
    chk("busy_after_done", 64'(busy), 64'd1);
    wait_first_write(20);
    wait_issue(5, 50);
    pulse_done();
    #1;
    chk("sync_err_set", 64'(sync_err), 64'd1);
    wait_frame_end(200);
    chk("sync_err_sticky", 64'(sync_err), 64'd1);

    // Pause at addr 9 for 7 cycles, resume from the same address
    pulse_done();
    wait_issue(8, 50);
    enable = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (rom_en) en_cnt++;
      sb_sample();
      @(negedge clk);
    end
    chk("no_issue_while_paused", 64'(en_cnt), 64'd0);
    chk("paused_state", 64'({busy, rom_addr}), 64'({1'b1, AW'(9)}));
    enable = 1'b1;
    #1;
    chk("resume_issue_addr9", 64'({rom_en, rom_addr}), 64'({1'b1, AW'(9)}));
    step();
    wait_frame_end(200);

    // Async reset between edges while draining the frame
    pulse_done();
    wait_issue(15, 100);
    #3;
    rst = 1'b0;
    #1;
    chk("reset_mid_drain_outputs",
        64'({rom_en, rom_addr, fifo_wr_en, busy, sync_err, fifo_din}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    exp_addr = 0;
    frame_wr = 0;
    rst = 1'b1;
    wait_first_write(20);
    wait_frame_end(200);
    chk("sync_err_cleared_by_reset", 64'(sync_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
